diff_serial_rx: RTL and testbench

Differential asynchronous serial receiver: the receive end of the tri-state differential output pair used on board-level links. It synchronises the P/N pair into the CLK domain and classifies each sample as a valid 1, a valid 0, or a line fault (P == N, e.g. a tri-stated or undriven transmitter). Valid samples are deserialised as start/data/stop frames, LSB first, at a fixed oversampling rate. Received bytes are presented on a valid/ready handshake to the downstream logic in the same clock domain.

---
 rtl/diff_serial_pkg.sv | 28 ++
 rtl/diff_sync2.sv | 51 +++++
 rtl/diff_serial_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_diff_serial_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/diff_serial_pkg.sv
// rtl/diff_serial_pkg.sv - shared types and sizing helpers for the differential serial receiver
//
// Purpose: FSM state encoding, classified line-sample encoding and the
// counter-width helper used by diff_serial_rx and diff_sync2.
// Ports: none (package).
package diff_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    L0,
    L1,
    LFAULT
  } line_e;

  // Width of a counter that must hold values 0 .. n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/diff_sync2.sv
// rtl/diff_sync2.sv - two-flop synchroniser and fault classifier for a differential pair
//
// Purpose: brings the asynchronous P/N legs into the CLK domain through two
// flops each and reports the synchronised line value and a fault flag.
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   RX_P       in   true leg (asynchronous)
//   RX_N       in   complement leg (asynchronous)
//   line_bit   out  synchronised P leg
//   line_fault out  synchronised P == N (undriven or shorted pair)
module diff_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic RX_P,
  input  logic RX_N,
  output logic line_bit,
  output logic line_fault
);

  logic p_meta_q, p_meta_d;
  logic p_sync_q, p_sync_d;
  logic n_meta_q, n_meta_d;
  logic n_sync_q, n_sync_d;

  always_comb begin
    p_meta_d = RX_P;
    p_sync_d = p_meta_q;
    n_meta_d = RX_N;
    n_sync_d = n_meta_q;
  end

  // Reset to an idle-high valid line so no false start follows reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_meta_q <= 1'b1;
      p_sync_q <= 1'b1;
      n_meta_q <= 1'b0;
      n_sync_q <= 1'b0;
    end else begin
      p_meta_q <= p_meta_d;
      p_sync_q <= p_sync_d;
      n_meta_q <= n_meta_d;
      n_sync_q <= n_sync_d;
    end
  end

  assign line_bit   = p_sync_q;
  assign line_fault = (p_sync_q == n_sync_q);

endmodule

// File: rtl/diff_serial_rx.sv
// rtl/diff_serial_rx.sv - differential asynchronous serial receiver with valid/ready output
//
// Purpose: deserialises start/data/stop frames (LSB first) from a differential
// pair at OVERSAMPLE clocks per bit, aborting on line faults, and holds each
// received byte for a downstream valid/ready consumer.
// Optional feature macro: DIFF_SERIAL_RX_PARITY_EN adds an even-parity bit
// after the data bits and the PAR_ERR output.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   RX_P, RX_N   asynchronous differential line
//   DOUT         received byte, stable while DVALID is high
//   DVALID       DOUT holds an unconsumed byte
//   DREADY       consumer accepts DOUT when DVALID && DREADY
//   FRAME_ERR    one-cycle pulse: bad stop bit or fault mid-frame
//   OVERRUN      one-cycle pulse: byte dropped, holding register full
//   LINE_FAULT   registered synchronised P == N
//   PAR_ERR      one-cycle pulse on parity mismatch (parity build only)
module diff_serial_rx
  import diff_serial_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_P,
  input  logic                 RX_N,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 DVALID,
  input  logic                 DREADY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 LINE_FAULT
`ifdef DIFF_SERIAL_RX_PARITY_EN
  ,
  output logic                 PAR_ERR
`endif
);

  localparam int CW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  logic  line_bit;
  logic  line_fault;
  line_e line_s;

  diff_sync2 u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P      (RX_P),
    .RX_N      (RX_N),
    .line_bit  (line_bit),
    .line_fault(line_fault)
  );

  always_comb begin
    if (line_fault)    line_s = LFAULT;
    else if (line_bit) line_s = L1;
    else               line_s = L0;
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dvalid_q, dvalid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 line_fault_q, line_fault_d;
  logic                 par_err_q, par_err_d;
  logic                 deliver;

  // Frame FSM: counters are cleared on every state change so they never
  // carry a value from one phase into the next.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (line_s == L0) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A 1 here is a glitch and a fault is not yet mid-frame: no error.
          if (line_s == L0) state_d = DATA;
          else              state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line_s == LFAULT) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end else begin
            shift_d   = {line_bit, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
`ifdef DIFF_SERIAL_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef DIFF_SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line_s == LFAULT) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
          end else if (line_bit != ^shift_q) begin
            // Even parity over data + parity bit failed: discard the byte.
            state_d   = IDLE;
            par_err_d = 1'b1;
          end else begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (line_s == L1) deliver     = 1'b1;
          else              frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Holding register: a delivery may replace a byte being consumed in the
  // same cycle; otherwise a full register drops the new byte.
  always_comb begin
    dout_d       = dout_q;
    dvalid_d     = dvalid_q;
    overrun_d    = 1'b0;
    line_fault_d = line_fault;
    if (deliver) begin
      if (!dvalid_q || DREADY) begin
        dout_d   = shift_q;
        dvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dvalid_q && DREADY) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      line_fault_q <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      line_fault_q <= line_fault_d;
      par_err_q    <= par_err_d;
    end
  end

  assign DOUT       = dout_q;
  assign DVALID     = dvalid_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;
  assign LINE_FAULT = line_fault_q;
`ifdef DIFF_SERIAL_RX_PARITY_EN
  assign PAR_ERR    = par_err_q;
`else
  // Parity state is never entered in this build; keep the flop tied off.
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule

// File: tb/tb_diff_serial_rx.sv
// tb/tb_diff_serial_rx.sv - scoreboard testbench for diff_serial_rx
module tb_diff_serial_rx;

  logic       clk;
  logic       rst;
  logic       rx_p;
  logic       rx_n;
  logic [7:0] dout;
  logic       dvalid;
  logic       dready;
  logic       frame_err;
  logic       overrun;
  logic       line_fault;
`ifdef DIFF_SERIAL_RX_PARITY_EN
  logic       par_err;
`endif

  diff_serial_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RX_P      (rx_p),
    .RX_N      (rx_n),
    .DOUT      (dout),
    .DVALID    (dvalid),
    .DREADY    (dready),
    .FRAME_ERR (frame_err),
    .OVERRUN   (overrun),
    .LINE_FAULT(line_fault)
`ifdef DIFF_SERIAL_RX_PARITY_EN
    ,
    .PAR_ERR   (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int fe_cnt;
  int ov_cnt;
  int dv_cycles;
  int rise_cyc;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: counts pulses and pops the scoreboard on each accepted byte.
  initial begin
    logic prev_dv;
    logic [7:0] e;
    prev_dv   = 1'b0;
    fe_cnt    = 0;
    ov_cnt    = 0;
    dv_cycles = 0;
    rise_cyc  = -1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
        if (dvalid) begin
          dv_cycles++;
          if (!prev_dv) rise_cyc = cyc;
        end
        if (dvalid && dready) begin
          if (exp_q.size() == 0) begin
            check("spurious_byte", int'(dout), -1);
          end else begin
            e = exp_q.pop_front();
            check("dout_byte", int'(dout), int'(e));
          end
        end
        prev_dv = dvalid;
      end
    end
  end

  // Callers are always at #1 after a rising edge; the next edge samples the pins.
  task automatic hold(input logic p, input logic n, input int cycles);
    rx_p = p;
    rx_n = n;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int pe);
    pe = cyc + 1;
    hold(1'b0, 1'b1, 16);
    for (int i = 0; i < 8; i++) hold(d[i], ~d[i], 16);
    hold(stop, ~stop, 16);
    hold(1'b1, 1'b0, 24);
  endtask

  initial begin
    int pe;
    int fe;
    int fe0;
    int dv0;
    int ov0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx_p   = 1'b1;
    rx_n   = 1'b0;
    dready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_dvalid", int'(dvalid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_line_fault", int'(line_fault), 0);
    rst = 1'b0;

    hold(1'b1, 1'b0, 500);
    check("idle_no_dvalid", dv_cycles, 0);
    check("idle_no_frame_err", fe_cnt, 0);

    // Frame 0xA5 with the consumer always ready.
    dv0 = dv_cycles;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, pe);
    check("a5_dvalid_rise_cycle", rise_cyc, pe + 154);
    check("a5_dvalid_one_cycle", dv_cycles - dv0, 1);

    // Short start glitch.
    dv0 = dv_cycles;
    fe0 = fe_cnt;
    hold(1'b0, 1'b1, 5);
    hold(1'b1, 1'b0, 40);
    check("glitch_no_dvalid", dv_cycles - dv0, 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);

    // Bad stop bit, then a good frame.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, pe);
    check("badstop_frame_err", fe_cnt - fe0, 1);
    check("badstop_no_dvalid", dv_cycles - dv0, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, pe);
    check("after_badstop_dvalid", dv_cycles - dv0, 1);

    // Overrun with the consumer stalled.
    dready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, pe);
    send_frame(8'h02, 1'b1, pe);
    check("overrun_pulse", ov_cnt - ov0, 1);
    check("overrun_dout_kept", int'(dout), 8'h01);
    check("overrun_dvalid_held", int'(dvalid), 1);
    dready = 1'b1;
    hold(1'b1, 1'b0, 3);
    check("overrun_dvalid_cleared", int'(dvalid), 0);

    // Line fault (P = N = 0) for 20 cycles during data bit 3 of 0x00.
    fe0 = fe_cnt;
    pe = cyc + 1;
    hold(1'b0, 1'b1, 16);
    for (int i = 0; i < 3; i++) hold(1'b0, 1'b1, 16);
    rx_p = 1'b0;
    rx_n = 1'b0;
    fe = cyc + 1;
    for (int k = 0; k < 30; k++) begin
      if (cyc == fe + 19) begin
        rx_p = 1'b1;
        rx_n = 1'b0;
      end
      @(negedge clk);
      if (cyc == fe + 1)  check("line_fault_before", int'(line_fault), 0);
      if (cyc == fe + 2)  check("line_fault_rise", int'(line_fault), 1);
      if (cyc == fe + 21) check("line_fault_last", int'(line_fault), 1);
      if (cyc == fe + 22) check("line_fault_fall", int'(line_fault), 0);
      @(posedge clk);
      #1;
    end
    hold(1'b1, 1'b0, 30);
    check("fault_frame_err", fe_cnt - fe0, 1);
    dv0 = dv_cycles;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, pe);
    check("after_fault_rise_cycle", rise_cyc, pe + 154);
    check("after_fault_dvalid", dv_cycles - dv0, 1);
    check("after_fault_no_frame_err", fe_cnt - fe0, 1);

    hold(1'b1, 1'b0, 20);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
